// File: rtl/det_monitor_pkg.sv
// Shared constants and helpers for the detection monitor slice.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package det_monitor_pkg;

  localparam int TS_W_DEF  = 16;
  localparam int CNT_W_DEF = 16;
  localparam int DEPTH_DEF = 4;

  // Width needed to hold an occupancy count from 0 to depth inclusive.
  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/det_monitor_if.sv
// Event stream carrying the timestamp at the head of the event FIFO.
// Latency: n/a (wiring only).
// Backpressure: ev_ready from the consumer; a beat moves when ev_valid and ev_ready are both high.
interface det_monitor_if
  import det_monitor_pkg::*;
#(
  parameter int TS_W = TS_W_DEF
) ();

  logic [TS_W-1:0] ev_ts;
  logic            ev_valid;
  logic            ev_ready;

  modport master (output ev_ts, output ev_valid, input ev_ready);
  modport slave  (input ev_ts, input ev_valid, output ev_ready);

endinterface

// File: rtl/det_ts_fifo.sv
// Synchronous show-ahead FIFO of timestamps with push/pop/clear and occupancy level.
// Latency: a push is visible at dout one cycle later; the head is read combinationally.
// Backpressure: none internally; the caller only pushes when room exists (or a pop frees it).
module det_ts_fifo
  import det_monitor_pkg::*;
#(
  parameter int W     = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      push,
  input  logic                      pop,
  input  logic [W-1:0]              din,
  output logic [W-1:0]              dout,
  output logic [lvl_w(DEPTH)-1:0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = lvl_w(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers wrap naturally since DEPTH is a power of two; reset and clear both empty the queue.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage write; entries are not reset because the level gates visibility.
  always_ff @(posedge clock) begin
    if (push && !reset && !clear) mem[wr_ptr] <= din;
  end

  // Empty FIFO presents zero so stale storage never leaks out.
  assign dout = (level != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/det_monitor.sv
// Timestamps detector hits, counts them (saturating) and queues timestamps for a consumer.
// Latency: an event in cycle N appears on ev_ts/ev_valid in cycle N+1 when the queue was empty.
// Backpressure: ev_ready pops the head; a full queue with no pop drops the event and sets overflow.
module det_monitor
  import det_monitor_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    det_i,
  input  logic                    enable,
  input  logic                    clear,
  det_monitor_if.master           ev,
  output logic [CNT_W-1:0]        det_count,
  output logic                    overflow,
  output logic [lvl_w(DEPTH)-1:0] fifo_level
);

  localparam int LVL_W = lvl_w(DEPTH);

  logic [TS_W-1:0] ts;
  logic            event_c;
  logic            full;
  logic            pop;
  logic            push;
  logic            drop;

  // A pop frees a slot in the same cycle, so a full queue can still take an event alongside it.
  assign event_c     = det_i & enable;
  assign full        = (fifo_level == LVL_W'(DEPTH));
  assign pop         = (fifo_level != '0) & ev.ev_ready;
  assign push        = event_c & (~full | pop);
  assign drop        = event_c & full & ~pop;
  assign ev.ev_valid = (fifo_level != '0);

  // Free-running timestamp, saturating detection count and sticky overflow.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      ts        <= '0;
      det_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (enable)                      ts        <= ts + TS_W'(1);
      if (event_c && det_count != '1)  det_count <= det_count + CNT_W'(1);
      if (drop)                        overflow  <= 1'b1;
    end
  end

  det_ts_fifo #(
    .W     (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (ts),
    .dout  (ev.ev_ts),
    .level (fifo_level)
  );

endmodule
